tag_release: RTL and testbench

- Write-side producer for the free-tag FIFO. It drives that FIFO's wdata/winc and obeys its wfull.
- After reset or flush, it refills the FIFO with every tag, 0..NTAGS-1, in order.
- During normal operation it takes up to two retired/squashed tags per cycle from the commit/CDB side. It holds them in a small pending queue and writes them into the FIFO one per cycle.
- Dispatch consumes tags from the FIFO read side. This block is the only writer.

---
 rtl/tag_release.sv | 110 +++++++++++
 tb/tb_tag_release.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_release.sv
// tag_release: write-side producer for the free-tag FIFO.
// After reset or flush it refills the FIFO with tags 0..NTAGS-1.
// It then forwards released tags from a small pending queue, one per cycle.
module tag_release #(
  parameter int DSIZE  = 5,
  parameter int NTAGS  = 32,
  parameter int PDEPTH = 4,
  parameter int PASIZE = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              flush,
  input  logic              wfull,
  output logic [DSIZE-1:0]  wdata,
  output logic              winc,
  input  logic              rel0_valid,
  input  logic [DSIZE-1:0]  rel0_tag,
  input  logic              rel1_valid,
  input  logic [DSIZE-1:0]  rel1_tag,
  output logic              rel_ready,
  output logic              init_busy,
  output logic [PASIZE:0]   pend_cnt,
  output logic              ovf_err
);

  // state | meaning
  // INIT  | refilling the FIFO with tags 0..NTAGS-1
  // RUN   | forwarding released tags from the pending queue
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [DSIZE-1:0] LAST_TAG = DSIZE'(NTAGS - 1);
  localparam logic [PASIZE:0]  DEPTH_C  = (PASIZE+1)'(PDEPTH);

  state_t             r_state;
  logic [DSIZE-1:0]   r_icnt;
  logic [DSIZE-1:0]   r_q [PDEPTH];
  logic [PASIZE-1:0]  r_head;
  logic [PASIZE-1:0]  r_tail;
  logic [PASIZE:0]    r_cnt;
  logic               r_ovf;

  logic               w_run;
  logic [PASIZE:0]    w_free;
  logic               w_acc0;
  logic               w_acc1;
  logic [PASIZE:0]    w_npush;
  logic               w_pop;
  logic               w_ovf_set;
  logic [PASIZE-1:0]  w_tail1;

  // Outputs are derived from registered state so a write is only issued when the FIFO can take it.
  // winc is gated by wrst_n so it drops the moment reset is asserted.
  always_comb begin
    w_run     = (r_state == S_RUN);
    w_free    = DEPTH_C - r_cnt;
    rel_ready = w_run && !flush && (w_free >= (PASIZE+1)'(2));
    winc      = wrst_n && !wfull && !flush && (w_run ? (r_cnt != '0) : 1'b1);
    wdata     = w_run ? r_q[r_head] : r_icnt;
    init_busy = !w_run;
    w_acc0    = rel_ready && rel0_valid;
    w_acc1    = rel_ready && rel1_valid;
    w_npush   = (PASIZE+1)'(w_acc0) + (PASIZE+1)'(w_acc1);
    w_pop     = w_run && winc;
    w_ovf_set = (rel0_valid || rel1_valid) && !rel_ready && !flush;
    w_tail1   = r_tail + PASIZE'(1);
  end

  assign pend_cnt = r_cnt;
  assign ovf_err  = r_ovf;

  // Control state: refill sequencing, queue pointers and the sticky overflow flag.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= S_INIT;
      r_icnt  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      if (flush) begin
        r_state <= S_INIT;
        r_icnt  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_cnt   <= '0;
      end else begin
        if (!w_run && winc) begin
          if (r_icnt == LAST_TAG) begin
            r_state <= S_RUN;
            r_icnt  <= '0;
          end else begin
            r_icnt  <= r_icnt + DSIZE'(1);
          end
        end
        if (w_pop) r_head <= r_head + PASIZE'(1);
        r_tail <= r_tail + w_npush[PASIZE-1:0];
        r_cnt  <= r_cnt + w_npush - (PASIZE+1)'(w_pop);
      end
    end
  end

  // Pending-queue storage; port 0 takes the earlier slot when both ports release together.
  always_ff @(posedge wclk) begin
    if (w_acc0) r_q[r_tail] <= rel0_tag;
    if (w_acc1) r_q[w_acc0 ? w_tail1 : r_tail] <= rel1_tag;
  end

endmodule

// File: tb/tb_tag_release.sv
// Scoreboard bench for tag_release: expected writes are queued by the stimulus
// and a negedge monitor checks every FIFO write against them.
module tb_tag_release;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       flush;
  logic       wfull;
  logic [4:0] wdata;
  logic       winc;
  logic       rel0_valid;
  logic [4:0] rel0_tag;
  logic       rel1_valid;
  logic [4:0] rel1_tag;
  logic       rel_ready;
  logic       init_busy;
  logic [2:0] pend_cnt;
  logic       ovf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  tag_release #(.DSIZE(5), .NTAGS(32), .PDEPTH(4), .PASIZE(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .flush(flush), .wfull(wfull),
    .wdata(wdata), .winc(winc),
    .rel0_valid(rel0_valid), .rel0_tag(rel0_tag),
    .rel1_valid(rel1_valid), .rel1_tag(rel1_tag),
    .rel_ready(rel_ready), .init_busy(init_busy),
    .pend_cnt(pend_cnt), .ovf_err(ovf_err)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int t = lo; t <= hi; t++) exp_q.push_back(t);
  endtask

  // Monitor: each negedge with winc=1 is a write on the following posedge.
  initial begin
    forever begin
      @(negedge wclk);
      if (winc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("write_data", int'(wdata), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst_n = 1'b0; flush = 1'b0; wfull = 1'b0;
    rel0_valid = 1'b0; rel0_tag = '0; rel1_valid = 1'b0; rel1_tag = '0;
    #2;
    chk("rst_winc", int'(winc), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_init_busy", int'(init_busy), 1);
    chk("rst_rel_ready", int'(rel_ready), 0);
    chk("rst_pend_cnt", int'(pend_cnt), 0);
    chk("rst_ovf_err", int'(ovf_err), 0);
    step(2);

    // Clean refill of all 32 tags.
    push_range(0, 31);
    wrst_n = 1'b1;
    #1;
    chk("refill_first_winc", int'(winc), 1);
    step(32);
    chk("refill_done_busy", int'(init_busy), 0);
    chk("refill_done_ready", int'(rel_ready), 1);
    chk("refill_done_winc", int'(winc), 0);
    chk("refill_q_drained", exp_q.size(), 0);

    // Dual release into an empty queue, then a single release on port 1 with a same-edge pop.
    exp_q.push_back(7); exp_q.push_back(12); exp_q.push_back(20);
    rel0_valid = 1'b1; rel0_tag = 5'd7; rel1_valid = 1'b1; rel1_tag = 5'd12;
    step(1);
    chk("pair_winc", int'(winc), 1);
    chk("pair_wdata", int'(wdata), 7);
    chk("pair_pend", int'(pend_cnt), 2);
    rel0_valid = 1'b0; rel1_tag = 5'd20;
    step(1);
    rel1_valid = 1'b0;
    chk("pushpop_pend", int'(pend_cnt), 2);
    chk("pushpop_wdata", int'(wdata), 12);
    step(1);
    chk("tail_wdata", int'(wdata), 20);
    chk("tail_pend", int'(pend_cnt), 1);
    step(1);
    chk("drain_winc", int'(winc), 0);
    chk("drain_pend", int'(pend_cnt), 0);

    // Fill the queue behind a full FIFO, then overflow it.
    wfull = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4);
    rel0_valid = 1'b1; rel0_tag = 5'd1; rel1_valid = 1'b1; rel1_tag = 5'd2;
    step(1);
    chk("full_pend2", int'(pend_cnt), 2);
    chk("full_ready2", int'(rel_ready), 1);
    chk("full_winc", int'(winc), 0);
    rel0_tag = 5'd3; rel1_tag = 5'd4;
    step(1);
    chk("full_pend4", int'(pend_cnt), 4);
    chk("full_ready4", int'(rel_ready), 0);
    chk("pre_ovf", int'(ovf_err), 0);
    rel0_tag = 5'd5; rel1_tag = 5'd6;
    step(1);
    rel0_valid = 1'b0; rel1_valid = 1'b0;
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_pend", int'(pend_cnt), 4);
    wfull = 1'b0;
    step(4);
    chk("ovf_drain_pend", int'(pend_cnt), 0);
    chk("ovf_drain_q", exp_q.size(), 0);

    // Three pending tags discarded by a flush.
    wfull = 1'b1;
    rel0_valid = 1'b1; rel0_tag = 5'd8; rel1_valid = 1'b1; rel1_tag = 5'd9;
    step(1);
    rel0_tag = 5'd10; rel1_valid = 1'b0;
    step(1);
    chk("preflush_pend", int'(pend_cnt), 3);
    rel0_tag = 5'd11;
    flush = 1'b1; wfull = 1'b0;
    #1;
    chk("flush_winc", int'(winc), 0);
    chk("flush_ready", int'(rel_ready), 0);
    step(1);
    flush = 1'b0; rel0_valid = 1'b0;
    push_range(0, 31);
    chk("postflush_pend", int'(pend_cnt), 0);
    chk("postflush_busy", int'(init_busy), 1);
    chk("postflush_wdata", int'(wdata), 0);
    chk("postflush_ovf", int'(ovf_err), 1);

    // Refill with a three-cycle stall at tag 5.
    step(5);
    chk("stall_pre_wdata", int'(wdata), 5);
    wfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_winc", int'(winc), 0);
      chk("stall_wdata", int'(wdata), 5);
      step(1);
    end
    wfull = 1'b0;
    step(27);
    chk("refill2_busy", int'(init_busy), 0);
    chk("refill2_q", exp_q.size(), 0);

    // Asynchronous reset in the middle of a refill.
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    push_range(0, 9);
    step(10);
    chk("midinit_wdata", int'(wdata), 10);
    chk("midinit_winc", int'(winc), 1);
    wrst_n = 1'b0;
    #1;
    chk("async_winc", int'(winc), 0);
    chk("async_wdata", int'(wdata), 0);
    chk("async_ovf", int'(ovf_err), 0);
    chk("async_pend", int'(pend_cnt), 0);
    chk("async_busy", int'(init_busy), 1);
    step(2);
    push_range(0, 31);
    wrst_n = 1'b1;
    step(32);
    chk("final_busy", int'(init_busy), 0);
    chk("final_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
